// File: rtl/dm_responder_if.sv
// dm_responder_if: MEM-stage load/store request and response bundle
interface dm_responder_if;
    logic        memRead;
    logic        memWrite;
    logic [31:0] inAddr;
    logic [31:0] writeData;
    logic [31:0] outData;
    logic        ack;
    logic        busy;
    logic        misalign;

    modport master (
        output memRead, memWrite, inAddr, writeData,
        input  outData, ack, busy, misalign
    );

    modport slave (
        input  memRead, memWrite, inAddr, writeData,
        output outData, ack, busy, misalign
    );
endinterface

// File: rtl/dm_responder.sv
// dm_responder: fixed-latency data memory answering MEM-stage loads and stores
module dm_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input logic          clk,
    input logic          rst,
    dm_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam bit SHORT = (LATENCY == 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [AW+1:0] addr;
    logic [31:0]   data;
    logic          wr;
    logic [31:0]   mem [DEPTH];
    logic          req;
    logic          go_done;
    logic          acc_wr;
    logic          acc_mis;
    logic [AW+1:0] acc_addr;
    logic [31:0]   acc_data;
    logic [AW-1:0] idx;
    logic          unused_addr;

    // Upper address bits alias and are deliberately dropped.
    assign unused_addr = ^bus.inAddr[31:AW+2];

    // Access happens on the edge entering DONE; with single-cycle latency that
    // edge is the accepting one, so the live inputs are used instead of the capture.
    always_comb begin
        req      = bus.memRead | bus.memWrite;
        go_done  = rst & ((state == IDLE & req & SHORT) | (state == WAIT & cnt == '0));
        acc_addr = state == IDLE ? bus.inAddr[AW+1:0] : addr;
        acc_data = state == IDLE ? bus.writeData : data;
        acc_wr   = state == IDLE ? bus.memWrite : wr;
        acc_mis  = acc_addr[1:0] != 2'b00;
        idx      = acc_addr[AW+1:2];
    end

    assign bus.busy = rst & ((state == IDLE & req) | state == WAIT);
    assign bus.ack  = state == DONE;

    // Storage array is not reset; go_done is already gated by rst.
    always_ff @(posedge clk) begin
        if (go_done & acc_wr & !acc_mis) mem[idx] <= acc_data;
    end

    // Request capture, latency countdown and load/misalign result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= '0;
            addr         <= '0;
            data         <= '0;
            wr           <= 1'b0;
            bus.outData  <= '0;
            bus.misalign <= 1'b0;
        end else begin
            bus.misalign <= go_done & acc_mis;
            if (go_done & !acc_wr) bus.outData <= acc_mis ? '0 : mem[idx];
            case (state)
                IDLE: if (req) begin
                    addr  <= bus.inAddr[AW+1:0];
                    data  <= bus.writeData;
                    wr    <= bus.memWrite;
                    cnt   <= CNT_INIT;
                    state <= SHORT ? DONE : WAIT;
                end
                WAIT: if (cnt == '0) state <= DONE;
                      else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: randomized transaction-level check of two responders (latency 2 and 1)
module tb_dm_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dm_responder_if bus0 ();
    dm_responder_if bus1 ();

    dm_responder #(.DEPTH(256), .LATENCY(2)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    dm_responder #(.DEPTH(256), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic        rd [2];
    logic        wr [2];
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [31:0] o  [2];
    logic        bz [2];
    logic        ak [2];
    logic        ms [2];

    assign bus0.memRead = rd[0];  assign bus0.memWrite = wr[0];
    assign bus0.inAddr  = ad[0];  assign bus0.writeData = wd[0];
    assign bus1.memRead = rd[1];  assign bus1.memWrite = wr[1];
    assign bus1.inAddr  = ad[1];  assign bus1.writeData = wd[1];
    assign o[0] = bus0.outData;   assign o[1] = bus1.outData;
    assign bz[0] = bus0.busy;     assign bz[1] = bus1.busy;
    assign ak[0] = bus0.ack;      assign ak[1] = bus1.ack;
    assign ms[0] = bus0.misalign; assign ms[1] = bus1.misalign;

    // Behavioural model: per-DUT expected outputs and word store.
    logic        exp_busy [2];
    logic        exp_ack  [2];
    logic        exp_mis  [2];
    logic [31:0] exp_out  [2];
    bit          out_known [2];
    logic [31:0] mem_model [2][256];
    bit          mem_known [2][256];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, want);
    endtask

    task automatic set_idle(input int d);
        rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = $urandom; wd[d] = $urandom;
        exp_busy[d] = 1'b0; exp_ack[d] = 1'b0; exp_mis[d] = 1'b0;
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            exp_busy[d] = 1'b0; exp_ack[d] = 1'b0; exp_mis[d] = 1'b0;
            exp_out[d] = 32'h0; out_known[d] = 1'b1;
        end
    endtask

    // One request held from cycle 0 until its ack cycle, then gap idle cycles.
    task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] v, input int gap);
        int lat = (d == 0) ? 2 : 1;
        int idx = int'((a >> 2) % 256);
        bit mis = (a % 4) != 0;
        for (int c = 0; c <= lat; c++) begin
            @(posedge clk); #1;
            rd[d] = r; wr[d] = w; ad[d] = a; wd[d] = v;
            exp_busy[d] = c < lat;
            exp_ack[d]  = c == lat;
            exp_mis[d]  = (c == lat) && mis;
            if (c == lat) begin
                if (w) begin
                    if (!mis) begin mem_model[d][idx] = v; mem_known[d][idx] = 1'b1; end
                end else if (r) begin
                    exp_out[d]   = mis ? 32'h0 : mem_model[d][idx];
                    out_known[d] = mis || mem_known[d][idx];
                end
            end
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            set_idle(d);
        end
    endtask

    bit checking = 1'b0;

    // Every cycle, compare both DUTs with the model away from the rising edge.
    always @(negedge clk) begin
        if (checking) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("busy%0d", d), 32'(bz[d]), 32'(exp_busy[d]));
                chk($sformatf("ack%0d", d), 32'(ak[d]), 32'(exp_ack[d]));
                chk($sformatf("misalign%0d", d), 32'(ms[d]), 32'(exp_mis[d]));
                if (out_known[d]) chk($sformatf("outData%0d", d), o[d], exp_out[d]);
            end
        end
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            set_idle(d);
            for (int i = 0; i < 256; i++) begin mem_model[d][i] = 32'h0; mem_known[d][i] = 1'b0; end
        end
        reset_model();
        checking = 1'b1;
        repeat (2) @(posedge clk);
        #7 rst = 1'b1;

        access(0, 0, 1, 32'h10, 32'hDEADBEEF, 1);
        chk("wr_keeps_out", o[0], 32'h0);
        access(0, 1, 0, 32'h10, 32'h0, 1);
        chk("rd_10", o[0], 32'hDEADBEEF);
        access(0, 0, 1, 32'h400, 32'h12345678, 0);
        access(0, 1, 0, 32'h000, 32'h0, 1);
        chk("alias_0", o[0], 32'h12345678);
        access(0, 0, 1, 32'h10, 32'hAAAAAAAA, 1);
        access(0, 0, 1, 32'h12, 32'h55555555, 1);
        access(0, 1, 0, 32'h10, 32'h0, 0);
        chk("rd_10_after_mis", o[0], 32'hAAAAAAAA);
        access(0, 1, 0, 32'h13, 32'h0, 1);
        chk("rd_13_mis", o[0], 32'h0);

        access(0, 0, 1, 32'h20, 32'h11111111, 1);
        @(posedge clk); #1;
        wr[0] = 1'b1; ad[0] = 32'h20; wd[0] = 32'h22222222; exp_busy[0] = 1'b1;
        @(posedge clk); #1;
        #2 rst = 1'b0;
        set_idle(0);
        reset_model();
        #1;
        chk("rst_out", o[0], 32'h0);
        chk("rst_ack", 32'(ak[0]), 32'h0);
        chk("rst_mis", 32'(ms[0]), 32'h0);
        chk("rst_busy", 32'(bz[0]), 32'h0);
        repeat (2) @(posedge clk);
        #7 rst = 1'b1;
        access(0, 1, 0, 32'h20, 32'h0, 1);
        chk("rd_20_aborted", o[0], 32'h11111111);

        access(0, 1, 1, 32'h30, 32'h0F0F0F0F, 0);
        chk("both_is_write", o[0], 32'h11111111);
        access(0, 1, 0, 32'h30, 32'h0, 1);
        chk("rd_30", o[0], 32'h0F0F0F0F);
        access(1, 1, 1, 32'h30, 32'h0F0F0F0F, 0);
        chk("both_is_write_l1", o[1], 32'h0);
        access(1, 1, 0, 32'h30, 32'h0, 1);
        chk("rd_30_l1", o[1], 32'h0F0F0F0F);

        for (int n = 0; n < 600; n++) begin
            int d = int'($urandom_range(0, 1));
            int op = int'($urandom_range(0, 3));
            logic [31:0] a = $urandom;
            logic [31:0] lo = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 3)) : 32'h0;
            a = (a & ~32'h3FF) | (32'($urandom_range(0, 15)) << 2) | lo;
            access(d, op != 1, op != 0, a, $urandom, int'($urandom_range(0, 2)));
        end
        @(posedge clk); #1;
        set_idle(0); set_idle(1);
        repeat (3) @(posedge clk);
        #1;
        checking = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
